acc_sequencer: RTL and testbench

Run-level initiator for `acc_controller`. It arms a sampling run with a `sample_trig` pulse and holds `address_enable` while the controller sweeps the rows. It counts `array_done` pulses until a programmed number of full sweeps has completed, then requests `stop`. It answers the controller's `cal_H` request with a timed calibration window closed by a `cal_done` pulse, and reports run completion or error to the host.

---
 rtl/acc_pkg.sv | 26 ++
 rtl/acc_seq_timer.sv | 26 ++
 rtl/acc_sequencer.sv | 126 ++++++++++++
 tb/tb_acc_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the acquisition run sequencer.
package acc_pkg;

  localparam int NUM_ROW = 64;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_TRIG     = 3'd1;
  localparam logic [2:0] ST_SWEEP    = 3'd2;
  localparam logic [2:0] ST_STOP_REQ = 3'd3;
  localparam logic [2:0] ST_WAIT_CAL = 3'd4;
  localparam logic [2:0] ST_CAL      = 3'd5;
  localparam logic [2:0] ST_WAIT_CLR = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    TRIG     = ST_TRIG,
    SWEEP    = ST_SWEEP,
    STOP_REQ = ST_STOP_REQ,
    WAIT_CAL = ST_WAIT_CAL,
    CAL      = ST_CAL,
    WAIT_CLR = ST_WAIT_CLR,
    DONE     = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/acc_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module acc_seq_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/acc_sequencer.sv
// Run-level initiator: triggers a sampling run, counts sweeps, requests stop,
// serves the calibration handshake and reports done/err to the host.
module acc_sequencer #(
  parameter int NUM_ROW    = acc_pkg::NUM_ROW,
  parameter int SWEEP_W    = 16,
  parameter int CAL_CYCLES = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic               abort,
  input  logic               array_done,
  input  logic               cal_H,
  output logic               sample_trig,
  output logic               stop,
  output logic               address_enable,
  output logic               cal_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_count,
  output logic [2:0]         state
);
  import acc_pkg::*;

  localparam int TOUT_W = $clog2(TIMEOUT);
  localparam int CAL_W  = $clog2(CAL_CYCLES);
  localparam int TW     = ((TOUT_W > CAL_W) ? TOUT_W : CAL_W) + 1;

  if (NUM_ROW < 1 || CAL_CYCLES < 1 || TIMEOUT < 7) begin : g_bad_params
    $error("acc_sequencer: NUM_ROW>=1, CAL_CYCLES>=1 and TIMEOUT>=7 are required");
  end

  seq_state_t         state_reg, state_next;
  logic [SWEEP_W-1:0] target_reg;
  logic [SWEEP_W-1:0] sweep_count_reg;
  logic               err_reg;
  logic               set_err;
  logic               start_accept;
  logic               last_sweep;
  logic               timer_load;
  logic [TW-1:0]      timer_value;
  logic               timer_expired;

  assign start_accept = (state_reg == IDLE) && start;
  // Compare one bit wider so a target of all-ones cannot wrap.
  assign last_sweep = array_done &&
                      (({1'b0, sweep_count_reg} + (SWEEP_W+1)'(1)) == {1'b0, target_reg});

  always_comb begin
    state_next = state_reg;
    set_err    = 1'b0;
    case (state_reg)
      IDLE:     if (start) state_next = (num_sweeps == '0) ? DONE : TRIG;
      TRIG:     state_next = SWEEP;
      SWEEP:    if (last_sweep || abort) state_next = STOP_REQ;
      STOP_REQ: state_next = WAIT_CAL;
      WAIT_CAL: begin
        if (cal_H) begin
          state_next = CAL;
        end else if (timer_expired) begin
          state_next = DONE;
          set_err    = 1'b1;
        end
      end
      CAL:      if (!cal_H || timer_expired) state_next = WAIT_CLR;
      WAIT_CLR: begin
        if (!cal_H) begin
          state_next = DONE;
        end else if (timer_expired) begin
          state_next = DONE;
          set_err    = 1'b1;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // The timer restarts on every state change; CAL counts its window, the
  // wait states count toward the timeout.
  assign timer_load  = (state_next != state_reg);
  assign timer_value = (state_next == CAL) ? TW'(CAL_CYCLES - 1) : TW'(TIMEOUT - 1);

  acc_seq_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      target_reg      <= '0;
      sweep_count_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_accept) begin
        target_reg      <= num_sweeps;
        sweep_count_reg <= '0;
        err_reg         <= 1'b0;
      end else begin
        if (state_reg == SWEEP && array_done && sweep_count_reg != '1) begin
          sweep_count_reg <= sweep_count_reg + SWEEP_W'(1);
        end
        if (set_err) err_reg <= 1'b1;
      end
    end
  end

  assign sample_trig    = (state_reg == TRIG);
  assign stop           = (state_reg == STOP_REQ);
  assign address_enable = (state_reg == SWEEP);
  assign cal_done       = (state_reg == CAL) && timer_expired;
  assign busy           = (state_reg != IDLE);
  assign done           = (state_reg == DONE);
  assign err            = err_reg;
  assign sweep_count    = sweep_count_reg;
  assign state          = state_reg;

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomized scoreboard bench for acc_sequencer: the driver predicts event
// cycles from the run rules, a negedge monitor pops and compares them.
module tb_acc_sequencer;

  localparam int SWEEP_W    = 16;
  localparam int CAL_CYCLES = 8;
  localparam int TIMEOUT    = 16;

  logic               clk = 1'b0;
  logic               reset, start, abort, array_done, cal_H;
  logic [SWEEP_W-1:0] num_sweeps;
  logic               sample_trig, stop, address_enable, cal_done, busy, done, err;
  logic [SWEEP_W-1:0] sweep_count;
  logic [2:0]         state;

  acc_sequencer #(
    .NUM_ROW(64), .SWEEP_W(SWEEP_W), .CAL_CYCLES(CAL_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_sweeps(num_sweeps),
    .abort(abort), .array_done(array_done), .cal_H(cal_H),
    .sample_trig(sample_trig), .stop(stop), .address_enable(address_enable),
    .cal_done(cal_done), .busy(busy), .done(done), .err(err),
    .sweep_count(sweep_count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
    int err;
  } exp_t;

  exp_t q_trig[$], q_stop[$], q_cal[$], q_done[$];
  int   q_rise[$], q_fall[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic aen_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input int n, input int e);
    mk.cyc = c;
    mk.cnt = n;
    mk.err = e;
  endfunction

  task automatic compare(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Monitor: every output event must match the oldest prediction of its kind.
  always @(negedge clk) begin
    if (sample_trig === 1'b1) begin
      $display("cycle %0d: sample_trig", cyc);
      if (q_trig.size() == 0) flag("unexpected_sample_trig");
      else begin
        compare("trig_cycle", cyc, q_trig[0].cyc);
        compare("trig_err_cleared", int'(err), 0);
        void'(q_trig.pop_front());
      end
    end
    if (stop === 1'b1) begin
      $display("cycle %0d: stop sweep_count=%0d", cyc, sweep_count);
      if (q_stop.size() == 0) flag("unexpected_stop");
      else begin
        compare("stop_cycle", cyc, q_stop[0].cyc);
        compare("stop_sweep_count", int'(sweep_count), q_stop[0].cnt);
        void'(q_stop.pop_front());
      end
    end
    if (cal_done === 1'b1) begin
      $display("cycle %0d: cal_done", cyc);
      if (q_cal.size() == 0) flag("unexpected_cal_done");
      else begin
        compare("cal_done_cycle", cyc, q_cal[0].cyc);
        void'(q_cal.pop_front());
      end
    end
    if (done === 1'b1) begin
      $display("cycle %0d: done sweep_count=%0d err=%0d", cyc, sweep_count, err);
      if (q_done.size() == 0) flag("unexpected_done");
      else begin
        compare("done_cycle", cyc, q_done[0].cyc);
        compare("done_sweep_count", int'(sweep_count), q_done[0].cnt);
        compare("done_err", int'(err), q_done[0].err);
        void'(q_done.pop_front());
      end
    end
    if (address_enable === 1'b1 && aen_prev !== 1'b1) begin
      $display("cycle %0d: address_enable rise", cyc);
      if (q_rise.size() == 0) flag("unexpected_address_enable_rise");
      else begin
        compare("aen_rise_cycle", cyc, q_rise[0]);
        void'(q_rise.pop_front());
      end
    end
    if (address_enable === 1'b0 && aen_prev === 1'b1) begin
      $display("cycle %0d: address_enable fall", cyc);
      if (q_fall.size() == 0) flag("unexpected_address_enable_fall");
      else begin
        compare("aen_fall_cycle", cyc, q_fall[0]);
        void'(q_fall.pop_front());
      end
    end
    aen_prev <= address_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // One host run. cal_mode: 0 normal, 1 cal_H drops early, 2 cal_H never
  // rises, 3 cal_H stuck high. amode: 0 none, 1 abort with pulse aat,
  // 2 lone abort after aat pulses.
  task automatic do_run(input int n, input int gap, input int amode, input int aat,
                        input int cal_mode, input int dly, input bit extra, input bit junk);
    int c0, a, r, e, g, cnt, done_c;
    bit stopped;
    c0 = cyc; a = 0; cnt = 0; stopped = 1'b0; done_c = 0;
    start = 1'b1;
    num_sweeps = SWEEP_W'(n);
    if (n == 0) begin
      q_done.push_back(mk(c0 + 1, 0, 0));
      tick();
      start = 1'b0;
      wait_until(c0 + 2);
      return;
    end
    q_trig.push_back(mk(c0 + 1, 0, 0));
    q_rise.push_back(c0 + 2);
    tick();
    start = 1'b0;
    num_sweeps = SWEEP_W'($urandom);
    tick();
    while (!stopped) begin
      g = (gap >= 0) ? gap : int'($urandom_range(8, extra ? 1 : 0));
      for (int i = 0; i < g; i++) begin
        if (extra && cnt == 1 && i == 0) begin
          start = 1'b1;
          num_sweeps = (n == 2) ? SWEEP_W'(3) : SWEEP_W'(2);
        end
        tick();
        start = 1'b0;
      end
      a = cyc;
      if (amode == 2 && cnt == aat) begin
        abort = 1'b1;
        stopped = 1'b1;
      end else begin
        array_done = 1'b1;
        cnt++;
        if (amode == 1 && cnt == aat) abort = 1'b1;
        stopped = (cnt == n) || (amode == 1 && cnt == aat);
      end
      tick();
      array_done = 1'b0;
      abort = 1'b0;
    end
    q_stop.push_back(mk(a + 1, cnt, 0));
    q_fall.push_back(a + 1);
    if (junk) begin
      abort = 1'b1; array_done = 1'b1; start = 1'b1;
      num_sweeps = SWEEP_W'($urandom_range(9, 1));
      tick();
      abort = 1'b0; array_done = 1'b0; start = 1'b0;
    end
    if (cal_mode == 2) begin
      done_c = a + 2 + TIMEOUT;
      q_done.push_back(mk(done_c, cnt, 1));
    end else begin
      r = a + 1 + ((dly > 0) ? dly : int'($urandom_range(6, 1)));
      wait_until(r);
      cal_H = 1'b1;
      if (cal_mode == 1) begin
        e = r + int'($urandom_range(CAL_CYCLES - 1, 1));
        done_c = e + 2;
        q_done.push_back(mk(done_c, cnt, 0));
        wait_until(e);
        cal_H = 1'b0;
      end else begin
        q_cal.push_back(mk(r + CAL_CYCLES, 0, 0));
        if (cal_mode == 3) begin
          done_c = r + CAL_CYCLES + 1 + TIMEOUT;
          q_done.push_back(mk(done_c, cnt, 1));
          wait_until(done_c);
          cal_H = 1'b0;
        end else begin
          e = r + CAL_CYCLES + int'($urandom_range(5, 1));
          done_c = e + 1;
          q_done.push_back(mk(done_c, cnt, 0));
          wait_until(e);
          cal_H = 1'b0;
        end
      end
    end
    wait_until(done_c + 1);
  endtask

  task automatic check_idle_after_reset(input string nm);
    compare({nm, "_state"}, int'(state), 0);
    compare({nm, "_busy"}, int'(busy), 0);
    compare({nm, "_sweep_count"}, int'(sweep_count), 0);
    compare({nm, "_address_enable"}, int'(address_enable), 0);
  endtask

  task automatic reset_in_sweep();
    int c0, x;
    c0 = cyc;
    start = 1'b1; num_sweeps = SWEEP_W'(3);
    q_trig.push_back(mk(c0 + 1, 0, 0));
    q_rise.push_back(c0 + 2);
    tick(); start = 1'b0;
    tick();
    array_done = 1'b1;
    tick(); array_done = 1'b0;
    tick();
    reset = 1'b1;
    x = cyc;
    q_fall.push_back(x + 1);
    tick();
    reset = 1'b0;
    check_idle_after_reset("rst_sweep");
    tick();
  endtask

  task automatic reset_in_cal();
    int c0, a, r;
    c0 = cyc;
    start = 1'b1; num_sweeps = SWEEP_W'(1);
    q_trig.push_back(mk(c0 + 1, 0, 0));
    q_rise.push_back(c0 + 2);
    tick(); start = 1'b0;
    tick();
    array_done = 1'b1;
    a = cyc;
    q_stop.push_back(mk(a + 1, 1, 0));
    q_fall.push_back(a + 1);
    tick(); array_done = 1'b0;
    r = a + 3;
    wait_until(r);
    cal_H = 1'b1;
    wait_until(r + 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cal_H = 1'b0;
    check_idle_after_reset("rst_cal");
    wait_until(r + CAL_CYCLES + 4);
  endtask

  initial begin
    int n, amode, aat, cm;
    reset = 1'b1; start = 1'b0; abort = 1'b0; array_done = 1'b0; cal_H = 1'b0;
    num_sweeps = '0;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); abort = 1'($urandom); array_done = 1'($urandom);
      cal_H = 1'($urandom); num_sweeps = SWEEP_W'($urandom);
      tick();
    end
    compare("reset_sample_trig", int'(sample_trig), 0);
    compare("reset_stop", int'(stop), 0);
    compare("reset_address_enable", int'(address_enable), 0);
    compare("reset_cal_done", int'(cal_done), 0);
    compare("reset_busy", int'(busy), 0);
    compare("reset_done", int'(done), 0);
    compare("reset_err", int'(err), 0);
    compare("reset_sweep_count", int'(sweep_count), 0);
    compare("reset_state", int'(state), 0);
    start = 1'b0; abort = 1'b0; array_done = 1'b0; cal_H = 1'b0; num_sweeps = '0;
    reset = 1'b0;
    tick();

    do_run(3, 383, 0, 0, 0, 4, 1'b0, 1'b0);   // normal run, pulses 384 apart
    do_run(0, -1, 0, 0, 0, -1, 1'b0, 1'b0);   // zero target
    do_run(5, -1, 1, 1, 0, -1, 1'b0, 1'b0);   // abort with first array_done
    do_run(2, -1, 0, 0, 2, -1, 1'b0, 1'b1);   // cal_H never rises
    do_run(1, -1, 0, 0, 0, -1, 1'b0, 1'b0);   // next start clears err
    do_run(3, -1, 0, 0, 0, -1, 1'b1, 1'b0);   // start during SWEEP ignored
    do_run(4, -1, 2, 2, 1, -1, 1'b0, 1'b0);   // lone abort, early cal_H drop
    do_run(2, -1, 0, 0, 3, -1, 1'b0, 1'b1);   // cal_H stuck high
    reset_in_sweep();
    reset_in_cal();

    for (int i = 0; i < 25; i++) begin
      n = int'($urandom_range(4, 0));
      amode = (n >= 1) ? int'($urandom_range(2, 0)) : 0;
      aat = 0;
      if (amode == 1) aat = int'($urandom_range(n, 1));
      if (amode == 2) aat = int'($urandom_range(n - 1, 0));
      cm = int'($urandom_range(3, 0));
      do_run(n, -1, amode, aat, cm, -1, 1'($urandom), 1'($urandom));
    end

    repeat (4) tick();
    while (q_trig.size() > 0) begin flag("missing_sample_trig"); void'(q_trig.pop_front()); end
    while (q_stop.size() > 0) begin flag("missing_stop"); void'(q_stop.pop_front()); end
    while (q_cal.size() > 0) begin flag("missing_cal_done"); void'(q_cal.pop_front()); end
    while (q_done.size() > 0) begin flag("missing_done"); void'(q_done.pop_front()); end
    while (q_rise.size() > 0) begin flag("missing_address_enable_rise"); void'(q_rise.pop_front()); end
    while (q_fall.size() > 0) begin flag("missing_address_enable_fall"); void'(q_fall.pop_front()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
